// File: rtl/pid_pkg.sv
// Shared types, derived widths and saturation helper for the multi-axis PID.
package pid_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_ERR,
        S_MUL_P,
        S_MUL_I,
        S_MUL_D,
        S_ACC,
        S_DONE
    } pid_state_t;

    // Sum of P + I + D needs three guard bits over the data width.
    function automatic int acc_width(input int data_w);
        return data_w + 3;
    endfunction

    // Unsigned gain is zero-extended by one bit before the signed multiply.
    function automatic int prod_width(input int data_w, input int gain_w);
        return data_w + gain_w + 1;
    endfunction

    localparam int ACC_W  = acc_width(16);
    localparam int PROD_W = prod_width(16, 8);

    // Saturate a sign-extended value into [lo, hi].
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] x,
        input longint             lo,
        input longint             hi
    );
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/multi_axis_pid_clamp.sv
// Parametrised signed saturator; ovf is high whenever the input was clipped.
module pid_clamp
    import pid_pkg::*;
#(
    parameter int     IN_W  = 17,
    parameter int     OUT_W = 16,
    parameter longint LO    = -32768,
    parameter longint HI    = 32767
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);
    logic signed [63:0] wide;
    logic signed [63:0] sat;

    // Widen, clip to the limits, then narrow to the output width.
    always_comb begin
        wide = 64'(din);
        sat  = sat_signed(wide, LO, HI);
        dout = OUT_W'(sat);
        ovf  = (sat != wide);
    end
endmodule

// File: rtl/multi_axis_pid.sv
// Time-multiplexed PID for NUM_AXES axes sharing a single gain x data multiplier.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; clear_state zeroes all loop state
// S_CAPTURE | latch setpoint, measured, gains and hold
// S_ERR     | err = sat(sp - meas) for the current axis
// S_MUL_P   | P = (kp * err) >>> FRAC_W
// S_MUL_I   | integ += (ki * err) >>> FRAC_W unless held or winding up
// S_MUL_D   | D = (kd * sat(err - prev_err)) >>> FRAC_W, prev_err <= err
// S_ACC     | clamp P + I + D into the shadow output, record clamp direction
// S_DONE    | outputs valid, done pulse
module multi_axis_pid
    import pid_pkg::*;
#(
    parameter int NUM_AXES = 3,
    parameter int DATA_W   = 16,
    parameter int GAIN_W   = 8,
    parameter int FRAC_W   = 4,
    parameter int INT_LIM  = 8192,
    parameter int OUT_MAX  = 32767,
    parameter int OUT_MIN  = -32768
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       clear_state,
    input  logic                       hold,
    input  logic [NUM_AXES*DATA_W-1:0] setpoint,
    input  logic [NUM_AXES*DATA_W-1:0] measured,
    input  logic [NUM_AXES*GAIN_W-1:0] kp,
    input  logic [NUM_AXES*GAIN_W-1:0] ki,
    input  logic [NUM_AXES*GAIN_W-1:0] kd,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_AXES*DATA_W-1:0] pid_out,
    output logic [NUM_AXES-1:0]        sat_flags
);
    localparam int     AW    = acc_width(DATA_W);
    localparam int     PW    = prod_width(DATA_W, GAIN_W);
    localparam int     AX_W  = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam longint D_MAX = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint D_MIN = -(longint'(1) <<< (DATA_W - 1));
    // Individual P/D/increment terms are held to DATA_W+1 bits so the
    // three-term sum can never wrap inside AW bits.
    localparam longint T_MAX = (longint'(1) <<< DATA_W) - 1;
    localparam longint T_MIN = -(longint'(1) <<< DATA_W);
    localparam logic [AX_W-1:0] LAST_AXIS = AX_W'(NUM_AXES - 1);

    pid_state_t state, state_nxt;
    logic [AX_W-1:0] axis;
    logic            last_axis;

    logic signed [DATA_W-1:0] sp_q     [NUM_AXES];
    logic signed [DATA_W-1:0] meas_q   [NUM_AXES];
    logic        [GAIN_W-1:0] kp_q     [NUM_AXES];
    logic        [GAIN_W-1:0] ki_q     [NUM_AXES];
    logic        [GAIN_W-1:0] kd_q     [NUM_AXES];
    logic                     hold_q;

    logic signed [AW-1:0]     integ_q    [NUM_AXES];
    logic signed [DATA_W-1:0] prev_err_q [NUM_AXES];
    logic signed [DATA_W-1:0] shadow_q   [NUM_AXES];
    logic [NUM_AXES-1:0]      sat_shadow;
    logic [NUM_AXES-1:0]      dir_pos_q;

    logic signed [DATA_W-1:0] err_q;
    logic signed [AW-1:0]     p_q;
    logic signed [AW-1:0]     d_q;

    logic signed [DATA_W:0]   err_raw;
    logic signed [DATA_W-1:0] err_c;
    logic signed [DATA_W:0]   diff_raw;
    logic signed [DATA_W-1:0] diff_c;
    logic        [GAIN_W-1:0] mul_gain;
    logic signed [DATA_W-1:0] mul_op;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_shr;
    logic signed [AW-1:0]     term_c;
    logic signed [AW-1:0]     int_raw;
    logic signed [AW-1:0]     int_c;
    logic signed [AW-1:0]     acc_sum;
    logic signed [DATA_W-1:0] out_c;
    logic                     out_ovf;
    logic                     wind_block;
    logic                     unused_err_ovf;
    logic                     unused_diff_ovf;
    logic                     unused_term_ovf;
    logic                     unused_int_ovf;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign last_axis = (axis == LAST_AXIS);

    // Error and derivative differences at DATA_W+1 bits before saturation.
    assign err_raw  = (DATA_W+1)'(sp_q[axis]) - (DATA_W+1)'(meas_q[axis]);
    assign diff_raw = (DATA_W+1)'(err_q) - (DATA_W+1)'(prev_err_q[axis]);

    pid_clamp #(.IN_W(DATA_W+1), .OUT_W(DATA_W), .LO(D_MIN), .HI(D_MAX)) u_err_clamp (
        .din(err_raw), .dout(err_c), .ovf(unused_err_ovf)
    );

    pid_clamp #(.IN_W(DATA_W+1), .OUT_W(DATA_W), .LO(D_MIN), .HI(D_MAX)) u_diff_clamp (
        .din(diff_raw), .dout(diff_c), .ovf(unused_diff_ovf)
    );

    // Select gain and operand for the single shared multiplier.
    always_comb begin
        mul_gain = kp_q[axis];
        mul_op   = err_q;
        case (state)
            S_MUL_I: mul_gain = ki_q[axis];
            S_MUL_D: begin
                mul_gain = kd_q[axis];
                mul_op   = diff_c;
            end
            default: ;
        endcase
    end

    assign prod     = PW'($signed({1'b0, mul_gain})) * PW'(mul_op);
    assign prod_shr = prod >>> FRAC_W;

    pid_clamp #(.IN_W(PW), .OUT_W(AW), .LO(T_MIN), .HI(T_MAX)) u_term_clamp (
        .din(prod_shr), .dout(term_c), .ovf(unused_term_ovf)
    );

    assign int_raw = integ_q[axis] + term_c;

    pid_clamp #(.IN_W(AW), .OUT_W(AW), .LO(-INT_LIM), .HI(INT_LIM)) u_int_clamp (
        .din(int_raw), .dout(int_c), .ovf(unused_int_ovf)
    );

    assign acc_sum = p_q + integ_q[axis] + d_q;

    pid_clamp #(.IN_W(AW), .OUT_W(DATA_W), .LO(OUT_MIN), .HI(OUT_MAX)) u_out_clamp (
        .din(acc_sum), .dout(out_c), .ovf(out_ovf)
    );

    // Freeze the integrator while the last pass clamped and err still pushes that way.
    assign wind_block = sat_flags[axis] &&
                        (dir_pos_q[axis] ? (!err_q[DATA_W-1] && (err_q != '0))
                                         : err_q[DATA_W-1]);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; clear_state takes priority over start in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (!clear_state && start) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_ERR;
            S_ERR:     state_nxt = S_MUL_P;
            S_MUL_P:   state_nxt = S_MUL_I;
            S_MUL_I:   state_nxt = S_MUL_D;
            S_MUL_D:   state_nxt = S_ACC;
            S_ACC:     state_nxt = last_axis ? S_DONE : S_ERR;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Snapshot of all inputs so they may change once the pass is under way.
    always_ff @(posedge clk) begin
        if (state == S_CAPTURE) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                sp_q[a]   <= setpoint[a*DATA_W +: DATA_W];
                meas_q[a] <= measured[a*DATA_W +: DATA_W];
                kp_q[a]   <= kp[a*GAIN_W +: GAIN_W];
                ki_q[a]   <= ki[a*GAIN_W +: GAIN_W];
                kd_q[a]   <= kd[a*GAIN_W +: GAIN_W];
            end
            hold_q <= hold;
        end
    end

    // Per-axis datapath and output registers; outputs publish on the edge into DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            axis       <= '0;
            err_q      <= '0;
            p_q        <= '0;
            d_q        <= '0;
            pid_out    <= '0;
            sat_flags  <= '0;
            sat_shadow <= '0;
            dir_pos_q  <= '0;
            for (int a = 0; a < NUM_AXES; a++) begin
                integ_q[a]    <= '0;
                prev_err_q[a] <= '0;
                shadow_q[a]   <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_state) begin
                        pid_out    <= '0;
                        sat_flags  <= '0;
                        sat_shadow <= '0;
                        dir_pos_q  <= '0;
                        for (int a = 0; a < NUM_AXES; a++) begin
                            integ_q[a]    <= '0;
                            prev_err_q[a] <= '0;
                            shadow_q[a]   <= '0;
                        end
                    end
                end
                S_CAPTURE: axis  <= '0;
                S_ERR:     err_q <= err_c;
                S_MUL_P:   p_q   <= term_c;
                S_MUL_I: begin
                    if (!hold_q && !wind_block) integ_q[axis] <= int_c;
                end
                S_MUL_D: begin
                    d_q              <= term_c;
                    prev_err_q[axis] <= err_q;
                end
                S_ACC: begin
                    shadow_q[axis]   <= out_c;
                    sat_shadow[axis] <= out_ovf;
                    dir_pos_q[axis]  <= !acc_sum[AW-1];
                    if (last_axis) begin
                        for (int a = 0; a < NUM_AXES; a++) begin
                            pid_out[a*DATA_W +: DATA_W] <= (AX_W'(a) == axis) ? out_c : shadow_q[a];
                            sat_flags[a]                <= (AX_W'(a) == axis) ? out_ovf : sat_shadow[a];
                        end
                    end else begin
                        axis <= axis + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/multi_axis_pid.md
# multi_axis_pid

Parametrised, time-multiplexed PID controller that computes NUM_AXES independent signed PID outputs per `start` request using one shared multiplier. It sits between the MPU attitude/measurement path and the motor PWM path in the flight controller. It adds per-axis runtime gains, saturation with flags, integral clamping with anti-windup, an integrator hold, and a synchronous state clear.

## Interface
- NUM_AXES, 3: number of axes.
- DATA_W, 16: signed width of setpoint, measurement and output.
- GAIN_W, 8: unsigned gain width.
- FRAC_W, 4: gain fraction bits, so a gain of 16 is 1.0.
- INT_LIM, 8192: symmetric integral clamp, ±INT_LIM.
- OUT_MAX, 32767: output upper clamp.
- OUT_MIN, -32768: output lower clamp.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request one computation pass; sampled only in IDLE.
- clear_state  in  1  zero integrals, prev_err, outputs and flags; honoured only in IDLE.
- hold  in  1  freeze integrators during the pass; captured at CAPTURE.
- setpoint  in  NUM_AXES*DATA_W  signed; axis i at [i*DATA_W +: DATA_W].
- measured  in  NUM_AXES*DATA_W  signed; same packing as setpoint.
- kp, ki, kd  in  NUM_AXES*GAIN_W each  per-axis unsigned gains.
- busy  out  1  high from CAPTURE through DONE.
- done  out  1  one-cycle pulse when pid_out is valid.
- pid_out  out  NUM_AXES*DATA_W  registered signed outputs.
- sat_flags  out  NUM_AXES  axis output was clamped on the last pass.

## Operation
- FSM states: IDLE → CAPTURE → per axis (ERR → MUL_P → MUL_I → MUL_D → ACC) → DONE → IDLE. The axis index increments after ACC and wraps to DONE after NUM_AXES-1.
- CAPTURE latches setpoint, measured, all gains and hold. Inputs may change freely afterwards.
- ERR: err = sat_DATA_W(sp − meas), computed at DATA_W+1 bits.
- MUL_P: P = (kp*err) >>> FRAC_W, arithmetic shift, i.e. floor.
- MUL_I: the integral is updated with integ += (ki*err) >>> FRAC_W, clamped to ±INT_LIM. It is not updated in any of these cases:
  - hold=1;
  - sat_flags[i]=1 and err has the sign of the previous clamp direction (anti-windup).
- MUL_D: D = (kd*sat_DATA_W(err − prev_err)) >>> FRAC_W. Then prev_err ← err.
- ACC: sum = P + integ + D, computed at DATA_W+3 bits and clamped to [OUT_MIN, OUT_MAX]. The result goes to a shadow register, and the flag plus clamp direction are recorded.
- DONE: all shadow values are copied to pid_out/sat_flags together, and done=1.
- clear_state in IDLE:
  - takes one cycle;
  - zeros integ, prev_err, pid_out and sat_flags;
  - wins over a simultaneous start, which is dropped.
- start while busy is ignored. No queueing.

## Timing
- Reset (rst_n low at a clk edge) forces the following, including mid-pass, where the partial results are discarded:
  - state = IDLE;
  - busy = 0, done = 0;
  - pid_out = 0, sat_flags = 0;
  - integrators = 0, prev_err = 0.
- Pass latency: start seen high in IDLE at edge 0, CAPTURE in cycle 1, axis states in cycles 2 to 1+5·NUM_AXES, DONE in cycle 2+5·NUM_AXES. For the default of 3 axes, done is high in cycle 17.
- pid_out changes only on the edge entering DONE and is stable at all other times.
- start may be held high. The next pass begins in the cycle after DONE returns to IDLE, so the minimum period is 3+5·NUM_AXES cycles.

## Structure
- Package pid_pkg holds:
  - the state enum pid_state_t;
  - the sat_signed width-parametrised saturation function;
  - the derived widths ACC_W = DATA_W+3 and PROD_W = DATA_W+GAIN_W+1.
- A single GAIN_W×DATA_W signed multiplier is shared by all axes and phases.
- Per-axis storage: integ, prev_err, shadow output, clamp direction.
- One natural sub-module: pid_clamp, a parametrised signed saturator with an overflow flag output. It is used for err, the derivative difference, the integral and the output.

## Test plan
- Proportional: axis0 kp=16, ki=kd=0, sp=100, meas=40 → pid_out[0]=60, done high exactly in cycle 17, busy high in cycles 1–17.
- Integral: ki=16, err=10, three passes → 10, 20, 30. With hold=1, a fourth pass → 30.
- Integral clamp: ki=255, err=32767, repeated passes → integ saturates at 8192 and never exceeds it. Negative error → clamp at −8192.
- Output saturation and anti-windup, with ki=0:
  - kp=255, err=10000 → pid_out=32767, sat_flags[0]=1.
  - Then ki=16, same positive err → integ does not grow.
  - err=−100 → integ decreases by 100.
- Derivative: kd=32, err 0 then 50 → D=100. Repeating err 50 → D=0.
- Control corner cases:
  - start asserted mid-pass → no extra pass;
  - clear_state together with start in IDLE → state zeroed, no busy;
  - rst_n low in cycle 9 → outputs 0 and IDLE on the next edge, and no done pulse.
